// File: rtl/ddr3_frame_reader.sv
// Read scheduler for ping-pong DDR3 frame buffers: picks one buffer per frame and streams it out as
// credit-gated Avalon-MM bursts. Define DDR3_FRAME_REPEAT_EN to re-read the last buffer when none is new.
module ddr3_frame_reader #(
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 64,
    parameter int BURST_LEN   = 32,
    parameter int FRAME_WORDS = 76800,
    parameter int SPACE_W     = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              buffer0_empty,
    input  logic              buffer1_empty,
    input  logic [ADDR_W-1:0] buffer0_offset,
    input  logic [ADDR_W-1:0] buffer1_offset,
    output logic              clear_buffer0,
    output logic              clear_buffer1,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [7:0]        avm_burstcount,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic [SPACE_W-1:0] fifo_space,
    output logic              fifo_wr,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              busy,
    output logic              frame_overrun
);
    localparam int CNT_W = $clog2(FRAME_WORDS + 1);

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_REQ, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              last_buf_q, last_buf_d;
    logic              buf_q, buf_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              read_q, read_d;
    logic              overrun_q, overrun_d;
`ifdef DDR3_FRAME_REPEAT_EN
    logic              rpt_q, rpt_d;
    logic              once_q, once_d;
`endif

    logic [SPACE_W:0]   outstanding;
    logic [SPACE_W+1:0] need;
    logic               space_ok;
    logic               beat;
    logic               pick_other;
    logic               pick_last;
    logic               clr_en;

    always_comb begin
        // Credit check: everything already requested but not yet returned must also fit in the FIFO.
        outstanding = (SPACE_W+1)'(req_cnt_q - beat_cnt_q);
        need        = {1'b0, outstanding} + (SPACE_W+2)'(BURST_LEN);
        space_ok    = {2'b00, fifo_space} >= need;
        beat        = avm_readdatavalid && (state_q == S_REQ || state_q == S_DRAIN);
        pick_other  = last_buf_q ? !buffer0_empty : !buffer1_empty;
        pick_last   = last_buf_q ? !buffer1_empty : !buffer0_empty;
`ifdef DDR3_FRAME_REPEAT_EN
        clr_en      = !rpt_q;
`else
        clr_en      = 1'b1;
`endif
    end

    always_comb begin
        state_d    = state_q;
        last_buf_d = last_buf_q;
        buf_d      = buf_q;
        addr_d     = addr_q;
        req_cnt_d  = req_cnt_q;
        beat_cnt_d = beat_cnt_q;
        read_d     = read_q;
        overrun_d  = overrun_q | (frame_start & (state_q != S_IDLE));
`ifdef DDR3_FRAME_REPEAT_EN
        rpt_d      = rpt_q;
        once_d     = once_q;
`endif
        if (beat) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                state_d = S_REQ;
                read_d  = 1'b0;
`ifdef DDR3_FRAME_REPEAT_EN
                rpt_d   = 1'b0;
`endif
                if (pick_other) begin
                    buf_d = !last_buf_q;
                end else if (pick_last) begin
                    buf_d = last_buf_q;
`ifdef DDR3_FRAME_REPEAT_EN
                end else if (once_q) begin
                    buf_d = last_buf_q;
                    rpt_d = 1'b1;
`endif
                end else begin
                    state_d = S_IDLE;
                end
                if (state_d == S_REQ) begin
                    last_buf_d = buf_d;
                    addr_d     = buf_d ? buffer1_offset : buffer0_offset;
                    req_cnt_d  = '0;
                    beat_cnt_d = '0;
                end
            end
            S_REQ: begin
                // Once raised, the request is held until the slave takes it, whatever the credit does.
                if (read_q) begin
                    if (!avm_waitrequest) begin
                        read_d    = 1'b0;
                        addr_d    = addr_q + ADDR_W'(BURST_LEN);
                        req_cnt_d = req_cnt_q + CNT_W'(BURST_LEN);
                        if (req_cnt_d == CNT_W'(FRAME_WORDS)) begin
                            state_d = S_DRAIN;
                        end
                    end
                end else if (space_ok) begin
                    read_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (beat_cnt_q == CNT_W'(FRAME_WORDS)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef DDR3_FRAME_REPEAT_EN
                once_d  = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            last_buf_q <= 1'b1;
            buf_q      <= 1'b0;
            addr_q     <= '0;
            req_cnt_q  <= '0;
            beat_cnt_q <= '0;
            read_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef DDR3_FRAME_REPEAT_EN
            rpt_q      <= 1'b0;
            once_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            last_buf_q <= last_buf_d;
            buf_q      <= buf_d;
            addr_q     <= addr_d;
            req_cnt_q  <= req_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            read_q     <= read_d;
            overrun_q  <= overrun_d;
`ifdef DDR3_FRAME_REPEAT_EN
            rpt_q      <= rpt_d;
            once_q     <= once_d;
`endif
        end
    end

    assign avm_read       = read_q;
    assign avm_address    = addr_q;
    assign avm_burstcount = 8'(BURST_LEN);
    assign fifo_wr        = beat;
    assign fifo_wr_data   = avm_readdata;
    assign busy           = (state_q != S_IDLE);
    assign frame_overrun  = overrun_q;
    assign clear_buffer0  = (state_q == S_DONE) && !buf_q && clr_en;
    assign clear_buffer1  = (state_q == S_DONE) && buf_q && clr_en;

endmodule

// File: tb/tb_ddr3_frame_reader.sv
// Bench for ddr3_frame_reader: randomised Avalon slave and credit FIFO model, per-frame scoreboard
// built from the buffer-selection rules, contiguous-address data expectations and credit invariant.
module tb_ddr3_frame_reader;
    localparam int ADDR_W  = 26;
    localparam int DATA_W  = 64;
    localparam int BL      = 32;
    localparam int FW      = 256;
    localparam int SPACE_W = 10;
    localparam int NB      = FW / BL;

    logic clk = 1'b0, reset_n = 1'b0, frame_start = 1'b0;
    logic buffer0_empty = 1'b1, buffer1_empty = 1'b1;
    logic [ADDR_W-1:0] buffer0_offset = '0, buffer1_offset = '0;
    logic clear_buffer0, clear_buffer1, avm_read, fifo_wr, busy, frame_overrun;
    logic avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
    logic [ADDR_W-1:0] avm_address;
    logic [7:0] avm_burstcount;
    logic [DATA_W-1:0] avm_readdata = '0, fifo_wr_data;
    logic [SPACE_W-1:0] fifo_space = '0;

    int errors = 0, checks = 0;

    // slave / FIFO model state
    int cap = 512, occ = 0, inflight = 0, max_inflight = 0, lat = 4, wait_pct = 0, drain_max = 2;
    int acc_n = 0, beats = 0, addr_err = 0, data_err = 0, wr_err = 0, ovf_err = 0, clr_err = 0;
    int c0 = 0, c1 = 0, stall_idx = -1, stall_left = 0, stall_seen = 0, stall_err = 0, cyc = 0;
    int beats_left = 0;
    bit flush = 1'b0, stray = 1'b0, stalling = 1'b0;
    logic [ADDR_W-1:0] exp_base = '0, stall_addr = '0, cur_addr = '0;
    logic [ADDR_W-1:0] pend_addr[$];
    int pend_t[$];
    logic [31:0] key = 32'h0;

    // reference model of the selection rules
    int exp_last = 1;
    bit once = 1'b0;

    ddr3_frame_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL), .FRAME_WORDS(FW), .SPACE_W(SPACE_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .buffer0_empty(buffer0_empty), .buffer1_empty(buffer1_empty),
        .buffer0_offset(buffer0_offset), .buffer1_offset(buffer1_offset),
        .clear_buffer0(clear_buffer0), .clear_buffer1(clear_buffer1),
        .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .avm_readdata(avm_readdata), .fifo_space(fifo_space), .fifo_wr(fifo_wr),
        .fifo_wr_data(fifo_wr_data), .busy(busy), .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem(input logic [ADDR_W-1:0] a);
        return {key ^ 32'(a), 32'(a) * 32'h9E3779B1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic clr_stats();
        acc_n = 0; beats = 0; addr_err = 0; data_err = 0; wr_err = 0; clr_err = 0;
        c0 = 0; c1 = 0; stall_seen = 0; stall_err = 0; ovf_err = 0; max_inflight = 0;
    endtask

    // Avalon slave, FIFO drain and monitors; inputs change on the falling edge.
    initial forever begin
        int d;
        logic [ADDR_W-1:0] ea;
        @(negedge clk);
        cyc++;
        d = $urandom_range(drain_max, 0);
        if (d > occ) d = occ;
        occ -= d;
        if (flush) begin
            pend_addr.delete(); pend_t.delete();
            beats_left = 0; inflight = 0; stalling = 1'b0;
            avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        end else begin
            if (stalling && (avm_read !== 1'b1 || avm_address !== stall_addr)) stall_err++;
            if (avm_read === 1'b1 && stall_idx == acc_n && stall_left > 0) begin
                if (!stalling) begin stalling = 1'b1; stall_addr = avm_address; end
                avm_waitrequest = 1'b1;
                stall_left--; stall_seen++;
            end else begin
                avm_waitrequest = ($urandom_range(99, 0) < wait_pct);
            end
            if (avm_read === 1'b1 && !avm_waitrequest) begin
                if (avm_address !== exp_base + ADDR_W'(acc_n * BL)) addr_err++;
                pend_addr.push_back(avm_address);
                pend_t.push_back(cyc + lat);
                acc_n++; inflight += BL; stalling = 1'b0;
            end
            avm_readdatavalid = 1'b0;
            if (stray) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = 64'hDEAD_BEEF_0BAD_F00D;
            end else begin
                if (beats_left == 0 && pend_t.size() > 0 && pend_t[0] <= cyc) begin
                    cur_addr = pend_addr.pop_front();
                    void'(pend_t.pop_front());
                    beats_left = BL;
                end
                if (beats_left > 0 && $urandom_range(3, 0) != 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = mem(cur_addr);
                    cur_addr++; beats_left--; inflight--;
                end
            end
        end
        #1;
        if (!flush) begin
            if (fifo_wr !== (avm_readdatavalid && !stray)) wr_err++;
            if (fifo_wr === 1'b1 && !stray) begin
                ea = exp_base + ADDR_W'(beats);
                if (fifo_wr_data !== mem(ea)) data_err++;
                beats++; occ++;
            end
        end
        fifo_space = SPACE_W'(cap - occ);
        if (inflight + occ > cap) ovf_err++;
        if (inflight > max_inflight) max_inflight = inflight;
        if (clear_buffer0 === 1'b1) begin c0++; buffer0_empty = 1'b1; if (beats != FW) clr_err++; end
        if (clear_buffer1 === 1'b1) begin c1++; buffer1_empty = 1'b1; if (beats != FW) clr_err++; end
    end

    task automatic do_frame(input string nm, input bit mid);
        int sel, n;
        bit rpt;
        rpt = 1'b0;
        if ((exp_last == 1) ? !buffer0_empty : !buffer1_empty) sel = 1 - exp_last;
        else if ((exp_last == 1) ? !buffer1_empty : !buffer0_empty) sel = exp_last;
`ifdef DDR3_FRAME_REPEAT_EN
        else if (once) begin sel = exp_last; rpt = 1'b1; end
`endif
        else sel = -1;
        exp_base = (sel == 1) ? buffer1_offset : buffer0_offset;
        clr_stats();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 4000) begin
            frame_start = (mid && n == 30);
            step();
            n++;
        end
        frame_start = 1'b0;
        chk({nm, "_idle"}, busy, 0);
        chk({nm, "_bursts"}, acc_n, (sel < 0) ? 0 : NB);
        chk({nm, "_beats"}, beats, (sel < 0) ? 0 : FW);
        chk({nm, "_addr_err"}, addr_err, 0);
        chk({nm, "_data_err"}, data_err, 0);
        chk({nm, "_wr_err"}, fifo_wr === 1'b0 ? wr_err : wr_err + 1, 0);
        chk({nm, "_clr_order"}, clr_err, 0);
        chk({nm, "_clear0"}, c0, (sel == 0 && !rpt) ? 1 : 0);
        chk({nm, "_clear1"}, c1, (sel == 1 && !rpt) ? 1 : 0);
        chk({nm, "_overflow"}, ovf_err, 0);
        if (sel >= 0) begin exp_last = sel; once = 1'b1; end
    endtask

    task automatic drain_fifo();
        for (int i = 0; i < 2000 && occ != 0; i++) step();
    endtask

    initial begin
        int n;
        key = $urandom;
        buffer0_offset = 26'h0100000;
        buffer1_offset = 26'h0200000;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_clear0", clear_buffer0, 0);
        chk("rst_clear1", clear_buffer1, 0);
        chk("rst_fifo_wr", fifo_wr, 0);
        chk("rst_overrun", frame_overrun, 0);
        chk("burstcount", avm_burstcount, BL);
        reset_n = 1'b1;
        step();

        clr_stats();
        stray = 1'b1;
        repeat (4) step();
        stray = 1'b0;
        step();
        chk("stray_wr_err", wr_err, 0);
        chk("stray_busy", busy, 0);

        buffer0_empty = 1'b0;
        do_frame("basic", 1'b0);

        buffer0_empty = 1'b0; buffer1_empty = 1'b0;
        buffer1_offset = 26'h3FFFFC0;
        wait_pct = 25; lat = $urandom_range(8, 1);
        do_frame("ping_b1_wrap", 1'b0);
        buffer1_offset = 26'h0200000 + ADDR_W'($urandom_range(1023, 0));
        do_frame("pong_b0", 1'b0);

        drain_fifo();
        cap = 40; lat = 10; wait_pct = 0;
        buffer1_empty = 1'b0;
        do_frame("flow", 1'b0);
        chk("flow_one_burst", max_inflight <= cap, 1);
        drain_fifo();
        cap = 512;

        lat = $urandom_range(6, 1);
        stall_idx = 3; stall_left = 5;
        buffer0_empty = 1'b0;
        do_frame("wait", 1'b0);
        chk("wait_stall_cycles", stall_seen, 5);
        chk("wait_stall_stable", stall_err, 0);
        stall_idx = -1;

        chk("pre_overrun", frame_overrun, 0);
        buffer1_empty = 1'b0;
        buffer0_offset = ADDR_W'($urandom) & 26'h3FFFFE0;
        wait_pct = 20;
        do_frame("overrun", 1'b1);
        chk("overrun_flag", frame_overrun, 1);

        do_frame("both_empty", 1'b0);

        buffer0_empty = 1'b0; buffer1_empty = 1'b1;
        exp_base = buffer0_offset;
        clr_stats();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        n = 0;
        while (acc_n < 3 && n < 2000) begin step(); n++; end
        chk("rst_mid_reached", acc_n >= 3, 1);
        flush = 1'b1;
        step();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_read", avm_read, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", avm_address, 0);
        chk("rst_mid_fifo_wr", fifo_wr, 0);
        chk("rst_mid_overrun", frame_overrun, 0);
        repeat (2) step();
        chk("rst_mid_no_clear", c0 + c1, 0);
        chk("rst_mid_b0_full", buffer0_empty, 0);
        reset_n = 1'b1;
        flush = 1'b0;
        exp_last = 1; once = 1'b0;
        step();
        do_frame("restart", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ddr3_frame_reader.md
Name: ddr3_frame_reader

Overview:
- Read-side scheduler for the ping-pong DDR3 frame buffers, in the ddr3_clk domain.
- Takes the buffer-full flags and word offsets from the CSR block and picks which buffer to display each frame.
- Issues Avalon-MM burst reads, with flow control from downstream pixel-FIFO space credits.
- Pulses clear_bufferN once a buffer has been fully read out.

Parameters:
- ADDR_W, 26, Avalon word-address width.
- DATA_W, 64, read data width.
- BURST_LEN, 32, words per burst (power of 2, ≤128).
- FRAME_WORDS, 76800, words per frame (multiple of BURST_LEN).
- SPACE_W, 10, width of fifo_space.

Ports:
- clk  in  1  DDR3 user clock.
- reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse per video frame, already synchronised to clk.
- buffer0_empty  in  1  buffer 0 holds no new frame.
- buffer1_empty  in  1  buffer 1 holds no new frame.
- buffer0_offset  in  ADDR_W  base word address of buffer 0.
- buffer1_offset  in  ADDR_W  base word address of buffer 1.
- clear_buffer0  out  1  one-cycle pulse: buffer 0 consumed.
- clear_buffer1  out  1  one-cycle pulse: buffer 1 consumed.
- avm_address  out  ADDR_W  burst start word address.
- avm_read  out  1  read request.
- avm_burstcount  out  8  always BURST_LEN.
- avm_waitrequest  in  1  slave stall.
- avm_readdatavalid  in  1  read data beat valid.
- avm_readdata  in  DATA_W  read data.
- fifo_space  in  SPACE_W  free words in the downstream pixel FIFO.
- fifo_wr  out  1  write strobe; equals avm_readdatavalid while a frame is active.
- fifo_wr_data  out  DATA_W  equals avm_readdata.
- busy  out  1  frame transfer in progress.
- frame_overrun  out  1  sticky: frame_start arrived while busy; cleared only by reset.

Behaviour:
- Reset: all outputs 0, state IDLE, last_buf=1, all counters 0.
- States:
  - IDLE → SELECT on frame_start.
  - SELECT (1 cycle): choose buf. Prefer ~last_buf if its empty flag is 0, else last_buf if its flag is 0. If neither, return to IDLE (see Optional Feature). On a choice, latch base offset, set addr=base, req_cnt=0, beat_cnt=0, last_buf=buf, go REQ.
  - REQ: assert avm_read when fifo_space ≥ outstanding+BURST_LEN, where outstanding = words requested − words received. Hold avm_read/avm_address stable until avm_waitrequest=0. On acceptance: addr+=BURST_LEN, req_cnt+=BURST_LEN. When req_cnt reaches FRAME_WORDS → DRAIN.
  - DRAIN: wait until beat_cnt == FRAME_WORDS → DONE.
  - DONE (1 cycle): pulse clear_bufferN for the chosen buf, → IDLE.
- beat_cnt counts avm_readdatavalid beats in REQ and DRAIN; each beat drives fifo_wr=1 in the same cycle (zero latency, combinational pass-through).
- readdatavalid outside REQ/DRAIN: ignored, no fifo_wr.
- Arithmetic: outstanding is held in SPACE_W+1 bits. Address increments wrap modulo 2^ADDR_W.
- busy=1 in every state except IDLE.
- frame_start seen while busy: frame_overrun set, pulse otherwise ignored.
- A buffer flag changing mid-frame has no effect on the frame in progress.
- Burst acceptance and the last beat in the same cycle are both counted.
- Async reset mid-frame aborts immediately. No clear pulse is issued, and the buffer stays full.

Optional Feature:
- Macro DDR3_FRAME_REPEAT_EN.
- Defined: in SELECT with both buffers empty, re-read last_buf's region, provided at least one frame has been read since reset. This path issues no clear pulse at DONE.
- Not defined: with both buffers empty, SELECT returns to IDLE and no reads are issued.

Test Plan:
- Basic frame: buffer0_empty=0, buffer0_offset=0x100000, FRAME_WORDS=256, BURST_LEN=32, fifo_space=512, frame_start pulse → 8 bursts at addresses 0x100000..0x1000E0 step 0x20, 256 fifo_wr beats, single clear_buffer0 pulse after the last beat, busy low.
- Ping-pong: both buffers full, last_buf=1 → frame 1 reads buffer 0 and clears it. Next frame_start with buffer 1 full → reads buffer1_offset and pulses clear_buffer1.
- Flow control: fifo_space=40, slave returns data with 10-cycle latency → no more than one burst outstanding, avm_read held low while space is short, no FIFO overflow.
- Waitrequest: avm_waitrequest high for 5 cycles on burst 3 → avm_read and avm_address held stable, then address advances by exactly 0x20.
- Overrun and empty: frame_start mid-frame → frame_overrun=1, transfer completes unchanged. frame_start with both buffers empty → no avm_read without the macro; with DDR3_FRAME_REPEAT_EN, the last buffer is re-read and no clear pulse is issued.
- Reset mid-frame: reset_n low after 3 bursts → all outputs 0 at once, no clear pulse. After release, next frame_start restarts the same buffer from its base offset.
